// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: frame-level UART receive controller.
// Detects the start edge, paces the oversampling edge counter, deserialises
// LSB-first data from the voted sample, checks optional parity and the stop
// bit, and presents good bytes on P_DATA with a one-cycle Data_Valid pulse.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [7:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  Sampled_Bit,
  output logic                  Sample_En,
  output logic [7:0]            Edge_Cnt,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stop_Err,
  output logic                  Busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  state_t                state;
  state_t                next_state;
  logic                  active_q;
  logic [7:0]            presc_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [3:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  perr_q;

  logic                  bit_end;
  logic                  par_exp;
  logic                  dv_d;
  logic                  perr_d;
  logic                  serr_d;

  // The last oversample edge of a bit is where every frame decision is made.
  assign bit_end = (state != IDLE) && (Edge_Cnt == (presc_q - 8'd1));
  assign par_exp = par_typ_q ? ~^shift_q : ^shift_q;

  // Sample_En and Busy are the same registered "not idle" flag.
  assign Sample_En = active_q;
  assign Busy      = active_q;

  // Next-state and flag-pulse decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    next_state = state;
    dv_d       = 1'b0;
    perr_d     = 1'b0;
    serr_d     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!RX_IN) next_state = START;
      end
      START: begin
        // A start bit that votes high was a glitch: drop it silently.
        if (bit_end) next_state = Sampled_Bit ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end && (bit_cnt == LAST_BIT)) next_state = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) begin
          perr_d     = (Sampled_Bit != par_exp);
          next_state = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          serr_d     = ~Sampled_Bit;
          dv_d       = Sampled_Bit & ~perr_q;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register plus the registered "frame in progress" flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      active_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // in the design samples the values from before this edge.
      state    <= next_state;
      active_q <= (next_state != IDLE);
    end
  end

  // Edge counter: held at 0 while idle, wraps at the latched Prescale-1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Edge_Cnt <= 8'd0;
    end else if ((state == IDLE) || (next_state == IDLE) || bit_end) begin
      Edge_Cnt <= 8'd0;
    end else begin
      Edge_Cnt <= Edge_Cnt + 8'd1;
    end
  end

  // Frame configuration is captured once per frame, on the start edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_q   <= 8'd0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else if ((state == IDLE) && !RX_IN) begin
      presc_q   <= Prescale;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
    end
  end

  // Deserialiser: each data bit enters at the MSB so the first (LSB) bit
  // ends up in bit 0 after DATA_WIDTH shifts.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt <= 4'd0;
      shift_q <= '0;
    end else if (bit_end) begin
      if (state == START) begin
        bit_cnt <= 4'd0;
      end else if (state == DATA) begin
        bit_cnt <= bit_cnt + 4'd1;
        shift_q <= {Sampled_Bit, shift_q[DATA_WIDTH-1:1]};
      end
    end
  end

  // Parity error memory: blocks Data_Valid for the rest of this frame only.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      perr_q <= 1'b0;
    end else if (perr_d) begin
      perr_q <= 1'b1;
    end else if ((state == STOP) && bit_end) begin
      perr_q <= 1'b0;
    end
  end

  // Registered one-cycle flag pulses and the output word.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stop_Err   <= 1'b0;
      P_DATA     <= '0;
    end else begin
      Data_Valid <= dv_d;
      Par_Err    <= perr_d;
      Stop_Err   <= serr_d;
      if (dv_d) P_DATA <= shift_q;
    end
  end

endmodule
